// File: rtl/uart_fifo_ctrl_if.sv
// Host-side and UART-side handshake/data signals of uart_fifo_ctrl.
// slave: the controller's view; master: the host plus UART-core view driving it.
// All signal widths are fixed (bytes are 8 bits, baud divider is 12 bits).
interface uart_fifo_ctrl_if;
    logic        tx_push;
    logic [7:0]  tx_data;
    logic        tx_full;
    logic        tx_idle;
    logic        rx_pop;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        baud_wr;
    logic [11:0] baud_wdata;
    logic        overflow;
    logic        err_clear;
    logic        uart_start_tx;
    logic [7:0]  uart_tx_value;
    logic        uart_tx_done;
    logic        uart_rx_available;
    logic [7:0]  uart_rx_value;
    logic        uart_rx_clear;
    logic [11:0] uart_baud_counter;

    modport slave (
        input  tx_push, tx_data, rx_pop, baud_wr, baud_wdata, err_clear,
               uart_tx_done, uart_rx_available, uart_rx_value,
        output tx_full, tx_idle, rx_data, rx_empty, overflow,
               uart_start_tx, uart_tx_value, uart_rx_clear, uart_baud_counter
    );

    modport master (
        output tx_push, tx_data, rx_pop, baud_wr, baud_wdata, err_clear,
               uart_tx_done, uart_rx_available, uart_rx_value,
        input  tx_full, tx_idle, rx_data, rx_empty, overflow,
               uart_start_tx, uart_tx_value, uart_rx_clear, uart_baud_counter
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Purpose: TX/RX byte FIFOs between a host and a UART core, plus baud register.
// Latency: push to uart_start_tx 2 cycles; uart_rx_available to rx_clear 1 cycle.
// Backpressure: full TX drops the push and sets sticky overflow; full RX leaves the UART byte unacknowledged.
// Ports: clk, rst_n (synchronous, active-low) and bus (uart_fifo_ctrl_if.slave):
//   host side tx_push/tx_data/tx_full/tx_idle, rx_pop/rx_data/rx_empty,
//   baud_wr/baud_wdata, overflow/err_clear; UART side uart_start_tx/uart_tx_value/
//   uart_tx_done, uart_rx_available/uart_rx_value/uart_rx_clear, uart_baud_counter.
module uart_fifo_ctrl #(
    parameter int          DEPTH      = 4,
    parameter logic [11:0] BAUD_RESET = 12'd103
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_fifo_ctrl_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_SEND, T_RELEASE} tx_state_t;
    typedef enum logic       {R_IDLE, R_ACK} rx_state_t;

    // ------------------------------------------------------------------ TX FIFO
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] tx_cnt;
    logic          tx_full_i;
    logic          tx_pop, tx_pop_ok, tx_push_ok, tx_load;
    logic          ovf_set;
    logic          overflow_q;
    logic [7:0]    tx_value_q;
    tx_state_t     tx_state, tx_state_nxt;

    assign tx_full_i  = (tx_cnt == FULL_CNT);
    assign tx_pop_ok  = tx_pop && (tx_cnt != '0);
    // A pop in the same cycle frees the slot, so a push to a full FIFO is accepted then.
    assign tx_push_ok = bus.tx_push && (!tx_full_i || tx_pop_ok);
    assign ovf_set    = bus.tx_push && tx_full_i && !tx_pop_ok;

    always_ff @(posedge clk) begin
        if (tx_push_ok) begin
            tx_mem[tx_wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push_ok, tx_pop_ok})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n)         overflow_q <= 1'b0;
        else if (ovf_set)   overflow_q <= 1'b1;
        else if (bus.err_clear) overflow_q <= 1'b0;
    end

    // ------------------------------------------------------------------ TX FSM
    always_ff @(posedge clk) begin
        if (!rst_n) tx_state <= T_IDLE;
        else        tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        tx_pop       = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (tx_cnt != '0) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = T_SEND;
                end
            end
            T_SEND: begin
                // Head stays in the FIFO until the UART reports the frame done.
                if (bus.uart_tx_done) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = T_RELEASE;
                end
            end
            T_RELEASE: begin
                if (!bus.uart_tx_done) tx_state_nxt = T_IDLE;
            end
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    // Byte is captured once on entry to T_SEND so it stays stable for the whole frame.
    always_ff @(posedge clk) begin
        if (!rst_n)       tx_value_q <= 8'h00;
        else if (tx_load) tx_value_q <= tx_mem[tx_rd_ptr];
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] rx_cnt;
    logic          rx_full_i, rx_empty_i;
    logic          rx_pop_ok, rx_push;
    rx_state_t     rx_state, rx_state_nxt;

    assign rx_full_i  = (rx_cnt == FULL_CNT);
    assign rx_empty_i = (rx_cnt == '0);
    assign rx_pop_ok  = bus.rx_pop && !rx_empty_i;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= bus.uart_rx_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push)   rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop_ok) rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop_ok})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------ RX FSM
    always_ff @(posedge clk) begin
        if (!rst_n) rx_state <= R_IDLE;
        else        rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_push      = 1'b0;
        case (rx_state)
            R_IDLE: begin
                // When full, the byte is left unacknowledged until a host pop makes room.
                if (bus.uart_rx_available && (!rx_full_i || rx_pop_ok)) begin
                    rx_push      = 1'b1;
                    rx_state_nxt = R_ACK;
                end
            end
            R_ACK: begin
                if (!bus.uart_rx_available) rx_state_nxt = R_IDLE;
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ baud register
    logic [11:0] baud_q;

    always_ff @(posedge clk) begin
        if (!rst_n)           baud_q <= BAUD_RESET;
        else if (bus.baud_wr) baud_q <= bus.baud_wdata;
    end

    // ------------------------------------------------------------------ outputs
    assign bus.tx_full           = tx_full_i;
    assign bus.tx_idle           = (tx_cnt == '0) && (tx_state == T_IDLE);
    assign bus.overflow          = overflow_q;
    assign bus.uart_start_tx     = (tx_state == T_SEND);
    assign bus.uart_tx_value     = tx_value_q;
    assign bus.rx_empty          = rx_empty_i;
    assign bus.rx_data           = rx_empty_i ? 8'h00 : rx_mem[rx_rd_ptr];
    assign bus.uart_rx_clear     = (rx_state == R_ACK);
    assign bus.uart_baud_counter = baud_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: TX path with a hand-driven UART model,
// TX overflow, RX path with backpressure, baud register and mid-frame reset.
module tb_uart_fifo_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    uart_fifo_ctrl_if bus ();

    uart_fifo_ctrl #(.DEPTH(4), .BAUD_RESET(12'd103)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs set afterwards apply at the next edge, outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for start_tx, check the byte, then complete the frame.
    task automatic serve_tx(input logic [7:0] exp);
        int n;
        n = 0;
        while (!bus.uart_start_tx && n < 50) begin
            tick();
            n++;
        end
        chk("tx_start_seen", 32'(bus.uart_start_tx), 32'd1);
        chk("tx_value", 32'(bus.uart_tx_value), 32'(exp));
        bus.uart_tx_done = 1'b1;
        tick();
        bus.uart_tx_done = 1'b0;
        tick();
    endtask

    // Offer a byte from the UART model; drop availability once acknowledged.
    task automatic offer_rx(input logic [7:0] v);
        int n;
        bus.uart_rx_available = 1'b1;
        bus.uart_rx_value     = v;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.uart_rx_clear && n < 20);
        chk("rx_clear_pulse", 32'(bus.uart_rx_clear), 32'd1);
        bus.uart_rx_available = 1'b0;
        tick();
    endtask

    task automatic pop_rx();
        bus.rx_pop = 1'b1;
        tick();
        bus.rx_pop = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [4];
        bit start_held;
        n_tests = 0;
        n_fail  = 0;

        rst_n                 = 1'b0;
        bus.tx_push           = 1'b0;
        bus.tx_data           = 8'h00;
        bus.rx_pop            = 1'b0;
        bus.baud_wr           = 1'b0;
        bus.baud_wdata        = 12'd0;
        bus.err_clear         = 1'b0;
        bus.uart_tx_done      = 1'b0;
        bus.uart_rx_available = 1'b0;
        bus.uart_rx_value     = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_tx_full",  32'(bus.tx_full), 32'd0);
        chk("rst_tx_idle",  32'(bus.tx_idle), 32'd1);
        chk("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
        chk("rst_rx_data",  32'(bus.rx_data), 32'h00);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_start",    32'(bus.uart_start_tx), 32'd0);
        chk("rst_rx_clear", 32'(bus.uart_rx_clear), 32'd0);
        chk("rst_tx_value", 32'(bus.uart_tx_value), 32'h00);
        chk("rst_baud",     32'(bus.uart_baud_counter), 32'd103);

        // Single byte A5, frame done 20 cycles after start
        bus.tx_push = 1'b1;
        bus.tx_data = 8'hA5;
        tick();
        bus.tx_push = 1'b0;
        chk("a5_not_idle", 32'(bus.tx_idle), 32'd0);
        tick();
        chk("a5_start", 32'(bus.uart_start_tx), 32'd1);
        chk("a5_value", 32'(bus.uart_tx_value), 32'hA5);
        start_held = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (!bus.uart_start_tx || bus.uart_tx_value != 8'hA5) start_held = 1'b0;
        end
        chk("a5_start_held", 32'(start_held), 32'd1);
        bus.uart_tx_done = 1'b1;
        tick();
        chk("a5_start_low", 32'(bus.uart_start_tx), 32'd0);
        chk("a5_release_not_idle", 32'(bus.tx_idle), 32'd0);
        bus.uart_tx_done = 1'b0;
        tick();
        chk("a5_idle", 32'(bus.tx_idle), 32'd1);

        // Five back-to-back pushes, UART stalled: fifth dropped
        for (int i = 1; i <= 5; i++) begin
            bus.tx_push = 1'b1;
            bus.tx_data = 8'(i);
            tick();
        end
        bus.tx_push = 1'b0;
        chk("ovf_set",  32'(bus.overflow), 32'd1);
        chk("ovf_full", 32'(bus.tx_full), 32'd1);
        tick();
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04;
        for (int i = 0; i < 4; i++) serve_tx(seq[i]);
        chk("ovf_drained_idle", 32'(bus.tx_idle), 32'd1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Drop coinciding with err_clear: set wins
        for (int i = 0; i < 4; i++) begin
            bus.tx_push = 1'b1;
            bus.tx_data = 8'(8'h40 + i);
            tick();
        end
        bus.err_clear = 1'b1;
        bus.tx_data   = 8'hEE;
        tick();
        bus.tx_push   = 1'b0;
        bus.err_clear = 1'b0;
        chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
        seq[0] = 8'h40; seq[1] = 8'h41; seq[2] = 8'h42; seq[3] = 8'h43;
        for (int i = 0; i < 4; i++) serve_tx(seq[i]);
        chk("ovf2_idle", 32'(bus.tx_idle), 32'd1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;

        // RX: two bytes, pop in order, pop on empty ignored
        offer_rx(8'h3C);
        chk("rx_clear_low", 32'(bus.uart_rx_clear), 32'd0);
        offer_rx(8'hC3);
        chk("rx_head_3c", 32'(bus.rx_data), 32'h3C);
        pop_rx();
        chk("rx_head_c3", 32'(bus.rx_data), 32'hC3);
        pop_rx();
        chk("rx_empty_after", 32'(bus.rx_empty), 32'd1);
        chk("rx_data_zero",   32'(bus.rx_data), 32'h00);
        pop_rx();
        chk("rx_pop_empty_ignored", 32'(bus.rx_empty), 32'd1);

        // RX full: fifth byte held off until a pop
        seq[0] = 8'h10; seq[1] = 8'h11; seq[2] = 8'h12; seq[3] = 8'h13;
        for (int i = 0; i < 4; i++) offer_rx(seq[i]);
        bus.uart_rx_available = 1'b1;
        bus.uart_rx_value     = 8'h77;
        tick();
        tick();
        tick();
        chk("rx_bp_no_clear", 32'(bus.uart_rx_clear), 32'd0);
        chk("rx_bp_head", 32'(bus.rx_data), 32'h10);
        bus.rx_pop = 1'b1;
        tick();
        bus.rx_pop = 1'b0;
        chk("rx_bp_accept", 32'(bus.uart_rx_clear), 32'd1);
        bus.uart_rx_available = 1'b0;
        tick();
        seq[0] = 8'h11; seq[1] = 8'h12; seq[2] = 8'h13; seq[3] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            chk("rx_bp_order", 32'(bus.rx_data), 32'(seq[i]));
            pop_rx();
        end
        chk("rx_bp_count4", 32'(bus.rx_empty), 32'd1);

        // Baud write
        bus.baud_wr    = 1'b1;
        bus.baud_wdata = 12'd15;
        tick();
        bus.baud_wr = 1'b0;
        chk("baud_15", 32'(bus.uart_baud_counter), 32'd15);

        // Reset mid-frame with RX content present
        offer_rx(8'h99);
        bus.tx_push = 1'b1;
        bus.tx_data = 8'h5A;
        tick();
        bus.tx_push = 1'b0;
        tick();
        chk("mid_start", 32'(bus.uart_start_tx), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_start",    32'(bus.uart_start_tx), 32'd0);
        chk("mid_rst_tx_idle",  32'(bus.tx_idle), 32'd1);
        chk("mid_rst_rx_empty", 32'(bus.rx_empty), 32'd1);
        chk("mid_rst_baud",     32'(bus.uart_baud_counter), 32'd103);
        chk("mid_rst_tx_value", 32'(bus.uart_tx_value), 32'h00);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_no_start", 32'(bus.uart_start_tx), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per FIFO (power of two, 2..16).
REQ-002 SHALL have parameter BAUD_RESET, default 12'd103, meaning baud divider value loaded at reset.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tx_push  input  1  write tx_data into TX FIFO this cycle.
REQ-006 SHALL have port tx_data  input  8  byte to transmit.
REQ-007 SHALL have port tx_full  output  1  TX FIFO holds DEPTH entries.
REQ-008 SHALL have port tx_idle  output  1  TX FIFO empty and TX FSM in T_IDLE.
REQ-009 SHALL have port rx_pop  input  1  remove head of RX FIFO this cycle.
REQ-010 SHALL have port rx_data  output  8  RX FIFO head, combinational; 8'h00 when empty.
REQ-011 SHALL have port rx_empty  output  1  RX FIFO holds no entries.
REQ-012 SHALL have port baud_wr  input  1  load baud_wdata into baud register.
REQ-013 SHALL have port baud_wdata  input  12  new baud divider.
REQ-014 SHALL have port overflow  output  1  sticky: push to full TX FIFO occurred.
REQ-015 SHALL have port err_clear  input  1  clears overflow.
REQ-016 SHALL have port uart_start_tx  output  1  start request to UART transmitter.
REQ-017 SHALL have port uart_tx_value  output  8  byte presented to UART transmitter.
REQ-018 SHALL have port uart_tx_done  input  1  UART transmitter finished frame.
REQ-019 SHALL have port uart_rx_available  input  1  UART holds a received byte.
REQ-020 SHALL have port uart_rx_value  input  8  received byte.
REQ-021 SHALL have port uart_rx_clear  output  1  acknowledge/release received byte.
REQ-022 SHALL have port uart_baud_counter  output  12  baud register value.

Function
REQ-023 TX FIFO and RX FIFO SHALL be DEPTH-entry circular buffers with wrap-around pointers and a count 0..DEPTH.
REQ-024 Push and pop on the same FIFO in one cycle SHALL both take effect, count unchanged; on an empty FIFO only the push takes effect.
REQ-025 tx_push while tx_full and no same-cycle TX pop SHALL be dropped and SHALL set overflow next cycle; err_clear clears it, set wins if both.
REQ-026 rx_pop while rx_empty SHALL be ignored.
REQ-027 TX FSM states T_IDLE, T_SEND, T_RELEASE.
REQ-028 T_IDLE: TX count>0 -> T_SEND, register head into uart_tx_value, uart_start_tx=1 next cycle.
REQ-029 T_SEND: uart_tx_done=1 -> pop TX head, uart_start_tx=0, go T_RELEASE; uart_tx_value held stable throughout T_SEND.
REQ-030 T_RELEASE: uart_tx_done=0 -> T_IDLE; minimum one idle cycle between frames.
REQ-031 RX FSM states R_IDLE, R_ACK.
REQ-032 R_IDLE: uart_rx_available=1 and (RX not full or rx_pop this cycle) -> push uart_rx_value, uart_rx_clear=1 next cycle, go R_ACK.
REQ-033 R_IDLE with RX FIFO full SHALL leave the byte unacknowledged (backpressure); no data loss.
REQ-034 R_ACK: uart_rx_available=0 -> uart_rx_clear=0, R_IDLE.
REQ-035 baud_wr SHALL update uart_baud_counter the following cycle, regardless of FSM state.
REQ-036 All outputs except rx_data SHALL be registered or decoded from registered state.

Reset
REQ-037 rst_n=0 at a clock edge SHALL empty both FIFOs, force T_IDLE/R_IDLE, uart_start_tx=0, uart_rx_clear=0, uart_tx_value=0, overflow=0, uart_baud_counter=BAUD_RESET; applies mid-frame, discarding in-flight bytes.
REQ-038 After reset: tx_full=0, tx_idle=1, rx_empty=1, rx_data=8'h00.

Verification
REQ-039 Push 8'hA5, UART model returns tx_done 20 cycles after start -> uart_tx_value=8'hA5, start_tx high until done, then low, tx_idle=1 after done falls.
REQ-040 Push 8'h01..8'h05 back-to-back with DEPTH=4, no UART progress -> fifth push dropped, overflow=1, bytes transmitted 01,02,03,04 in order; err_clear -> overflow=0.
REQ-041 UART model offers 8'h3C, 8'hC3 in sequence -> each acknowledged by rx_clear pulse, rx_data=8'h3C, pop -> 8'hC3, pop -> rx_empty=1, rx_data=8'h00.
REQ-042 Fill RX FIFO (4 bytes), offer 5th byte 8'h77 -> rx_clear stays 0; rx_pop -> 8'h77 accepted same cycle, count remains 4.
REQ-043 baud_wr with 12'd15 -> uart_baud_counter=15 next cycle; assert rst_n=0 during T_SEND -> start_tx=0, FIFOs empty, baud=103.
